// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU
// instructions, used in the execute stage. An operation is accepted in IDLE.
// Divide-by-zero and signed overflow finish on the accept edge. Every other
// operation runs one restoring step per clock for XLEN clocks. While it
// computes, the unit asks the hazard unit to stall. It then presents a
// registered result with a one-cycle done pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      div_inst qualified valid in EX; sampled only in IDLE
//   divsel     001 DIV, 010 DIVU, 011 REM, 100 REMU; other codes ignored
//   op_a       dividend (rs1)
//   op_b       divisor  (rs2)
//   flush      pipeline flush; aborts an operation in flight
//   stall_req  combinational stall request to the hazard unit
//   done       one-cycle pulse; result is valid in that cycle
//   result     registered quotient or remainder
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      divsel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   quo;       // holds |dividend| at first; quotient bits shift in
  logic [XLEN:0]     rem;       // partial remainder, one extra bit for the trial subtract
  logic [XLEN-1:0]   divisor;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q;
  logic              neg_r;
  logic              sel_rem;

  // Two's-complement negate when neg is set. This is used both for taking
  // magnitudes and for restoring the sign of the final result.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  // Decode the operation.
  logic op_legal;
  logic op_signed;
  logic op_rem;

  always_comb begin
    op_legal  = 1'b0;
    op_signed = 1'b0;
    op_rem    = 1'b0;
    case (divsel)
      3'b001: begin op_legal = 1'b1; op_signed = 1'b1;                  end
      3'b010: begin op_legal = 1'b1;                                    end
      3'b011: begin op_legal = 1'b1; op_signed = 1'b1; op_rem = 1'b1;  end
      3'b100: begin op_legal = 1'b1;                   op_rem = 1'b1;  end
      default: ;
    endcase
  end

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   sign_a;
  logic                   sign_b;
  logic                   launch;
  logic                   div_by_zero;
  logic                   overflow;

  assign a_s    = op_a;
  assign b_s    = op_b;
  assign sign_a = op_signed && (a_s < 0);
  assign sign_b = op_signed && (b_s < 0);

  // A flush in the same cycle as start takes priority, so nothing launches.
  assign launch      = (state == IDLE) && start && op_legal && !flush;
  assign div_by_zero = (op_b == '0);
  assign overflow    = op_signed && (op_a == MIN_NEG) && (op_b == ALL_ONES);

  // The stall stays high through the last CALC cycle. It drops in DONE, so
  // the pipeline advances in the same cycle that it consumes the result.
  assign stall_req = launch || (state == CALC);

  // One restoring step: shift {rem,quo} left by one bit and try to subtract
  // the divisor. The top bit of the widened difference is the borrow.
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  always_comb begin
    shifted = {rem[XLEN-1:0], quo[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    rem_nxt = shifted;
    quo_nxt = {quo[XLEN-2:0], 1'b0};
    if (!diff[XLEN+1]) begin
      rem_nxt = diff[XLEN:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            sel_rem <= op_rem;
            if (div_by_zero) begin
              result <= op_rem ? op_a : ALL_ONES;
              done   <= 1'b1;
              state  <= DONE;
            end else if (overflow) begin
              result <= op_rem ? '0 : MIN_NEG;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              quo     <= cond_neg(op_a, sign_a);
              divisor <= cond_neg(op_b, sign_b);
              rem     <= '0;
              cnt     <= '0;
              neg_q   <= sign_a ^ sign_b;
              neg_r   <= sign_a;
              state   <= CALC;
            end
          end
        end

        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              // The final step's values go straight to the output register.
              result <= sel_rem ? cond_neg(rem_nxt[XLEN-1:0], neg_r)
                                : cond_neg(quo_nxt, neg_q);
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end

        DONE: begin
          // A flush here gives the same result: done is already low next cycle.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [2:0]      divsel;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] result;

  div_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .divsel    (divsel),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  int              vectors    = 0;
  int              miscompares = 0;
  logic [31:0]     exp_q[$];
  logic [31:0]     last_result;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V division semantics in plain wide arithmetic.
  // In 64-bit math, the signed overflow case gives 2^31 for the quotient and
  // 0 for the remainder. Truncated to 32 bits, those are the architectural
  // results.
  function automatic logic [31:0] model(input logic [2:0] sel, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (sel)
      3'b001:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'b010:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b011:  return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Number of clock edges after the accept edge until done is visible.
  function automatic int model_latency(input logic [2:0] sel, input logic [31:0] a,
                                       input logic [31:0] b);
    bit sgn;
    sgn = (sel == 3'b001) || (sel == 3'b011);
    if (b == 0) return 0;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return XLEN;
  endfunction

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else                   check("result", result, exp_q.pop_front());
    end
  end

  task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    int n;
    bit st_ok;
    @(negedge clk);
    start = 1'b1; divsel = sel; op_a = a; op_b = b;
    #1;
    check("stall_on_start", 32'(stall_req), 32'd1);
    exp_q.push_back(model(sel, a, b));
    last_result = model(sel, a, b);
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    n = 0; st_ok = 1'b1;
    while (!done && n < XLEN + 8) begin
      if (!stall_req) st_ok = 1'b0;
      if (poke && n == 5) begin
        start  = 1'b1;
        divsel = 3'(1 + $urandom_range(0, 3));
        op_a   = $urandom;
        op_b   = $urandom_range(1, 100);
      end
      @(posedge clk); #1;
      n++;
    end
    // start stays high through the DONE cycle; it must be dropped before IDLE.
    start = 1'b0;
    check("stall_calc", 32'(st_ok), 32'd1);
    check("latency", n, model_latency(sel, a, b));
    check("stall_in_done", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic [2:0]  s;
    logic [31:0] a;
    logic [31:0] b;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; divsel = 3'b000; op_a = '0; op_b = '0;
    last_result = '0;
    #12;
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_stall", 32'(stall_req), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed operations
    run_op(3'b010, 32'd100, 32'd7, 1'b0);
    run_op(3'b100, 32'd100, 32'd7, 1'b0);
    run_op(3'b001, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b011, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(3'b010, 32'd5, 32'd0, 1'b0);
    run_op(3'b100, 32'd5, 32'd0, 1'b0);
    run_op(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b001, 32'h8000_0000, 32'd1, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd1, 1'b0);

    // A flush in CALC aborts: there is no done, and the old result is kept.
    @(negedge clk);
    start = 1'b1; divsel = 3'b001; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_stall", 32'(stall_req), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result", result, last_result);
    repeat (XLEN + 4) @(posedge clk);
    run_op(3'b010, 32'd9, 32'd3, 1'b0);

    // If start and flush arrive in the same cycle, flush wins.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; divsel = 3'b010; op_a = 32'd50; op_b = 32'd5;
    #1;
    check("flush_start_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", 32'(stall_req), 32'd0);
    repeat (XLEN + 2) @(posedge clk);

    // A reset in the middle of CALC abandons the operation.
    @(negedge clk);
    start = 1'b1; divsel = 3'b001; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_result", result, 32'd0);
    check("midreset_stall", 32'(stall_req), 32'd0);
    last_result = '0;
    @(negedge clk); rst_n = 1'b1;
    run_op(3'b100, 32'd17, 32'd5, 1'b0);

    // A start issued during CALC/DONE is ignored.
    run_op(3'b001, 32'd1000, 32'd33, 1'b1);

    // Illegal divsel codes are ignored.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b1; divsel = (k == 0) ? 3'b000 : 3'(4 + k); op_a = 32'd10; op_b = 32'd2;
      #1;
      check("illegal_stall", 32'(stall_req), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      check("illegal_done", 32'(done), 32'd0);
      check("illegal_idle", 32'(stall_req), 32'd0);
    end
    start = 1'b0;

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      s = 3'(1 + $urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      run_op(s, a, b, ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
